// File: rtl/arith_pkg.sv
// arith_pkg: state encoding and sizing helper shared by the iterative arithmetic blocks
package arith_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Counter width that never collapses to zero bits, even for a single chunk
    function automatic int clog2(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/cla_nbits.sv
// cla_nbits: combinational n-bit carry-lookahead adder
//   a, b : n-bit addends
//   cin  : carry-in
//   s    : n-bit sum
//   cout : carry-out
module cla_nbits #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] s,
    output logic         cout
);

    logic [n-1:0] g, p;
    logic [n:0]   c;

    // Each carry is flattened from g/p/cin alone rather than from the previous carry
    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < n; i++) begin
            c[i+1] = cin;
            for (int j = 0; j <= i; j++) c[i+1] = g[j] | (p[j] & c[i+1]);
        end
        s    = p ^ c[n-1:0];
        cout = c[n];
    end

endmodule

// File: rtl/sub_nbits_seq.sv
// sub_nbits_seq: multi-cycle subtractor d = x - y - bin, W bits per cycle LSB-first
//   clk, rst : clock, asynchronous active-high reset
//   start    : request, taken when ready=1
//   x, y, bin: minuend, subtrahend, borrow-in (latched on accepted start)
//   ready    : start will be accepted (IDLE/DONE)
//   busy     : operation in progress
//   done     : one-cycle result-valid pulse
//   d        : difference, held until the next operation completes
//   bout     : borrow-out (x < y + bin), held with d
//   zero     : d == 0, held with d
module sub_nbits_seq
    import arith_pkg::*;
#(
    parameter int N = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         bin,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         zero
);

    localparam int NCH = N / W;
    localparam int CW  = clog2(NCH);

    if (N % W != 0) begin : g_bad_width
        $error("sub_nbits_seq: N must be a multiple of W");
    end

    state_t        state;
    logic [CW-1:0] cnt;
    logic          borrow;
    logic [N-1:0]  xr, yr, acc, res;
    logic [W-1:0]  s;
    logic          c;

    // Subtract as x + ~y + ~borrow; carry-out low means a borrow into the next chunk
    cla_nbits #(.n(W)) u_cla (
        .a   (xr[W-1:0]),
        .b   (~yr[W-1:0]),
        .cin (~borrow),
        .s   (s),
        .cout(c)
    );

    // Operands shift down so the active chunk is always at the bottom; the
    // working register fills from the top, landing chunk k at slice k after NCH steps
    assign res = (acc >> W) | (N'(s) << (N - W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            borrow <= 1'b0;
            xr     <= '0;
            yr     <= '0;
            acc    <= '0;
            d      <= '0;
            bout   <= 1'b0;
            zero   <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        xr     <= x;
                        yr     <= y;
                        borrow <= bin;
                        cnt    <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                        ready  <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    xr     <= xr >> W;
                    yr     <= yr >> W;
                    acc    <= res;
                    borrow <= ~c;
                    if (cnt == CW'(NCH - 1)) begin
                        state <= DONE;
                        d     <= res;
                        bout  <= ~c;
                        zero  <= res == '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_nbits_seq.sv
// tb_sub_nbits_seq: directed and random checks of sub_nbits_seq at W=4, W=1 and W=8
module tb_sub_nbits_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, bin = 1'b0;
    logic [7:0] x = '0, y = '0;
    logic       ready, busy, done, bout, zero;
    logic [7:0] d;

    logic       rstart = 1'b0, rbin = 1'b0;
    logic [7:0] rx = '0, ry = '0;
    logic       ready1, busy1, done1, bout1, zero1;
    logic       ready8, busy8, done8, bout8, zero8;
    logic [7:0] d1, d8;

    int pass_cnt = 0, total_cnt = 0;

    always #5 clk = ~clk;

    sub_nbits_seq #(.N(8), .W(4)) u4 (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .bin(bin),
        .ready(ready), .busy(busy), .done(done), .d(d), .bout(bout), .zero(zero)
    );

    sub_nbits_seq #(.N(8), .W(1)) u1 (
        .clk(clk), .rst(rst), .start(rstart), .x(rx), .y(ry), .bin(rbin),
        .ready(ready1), .busy(busy1), .done(done1), .d(d1), .bout(bout1), .zero(zero1)
    );

    sub_nbits_seq #(.N(8), .W(8)) u8 (
        .clk(clk), .rst(rst), .start(rstart), .x(rx), .y(ry), .bin(rbin),
        .ready(ready8), .busy(busy8), .done(done8), .d(d8), .bout(bout8), .zero(zero8)
    );

    typedef struct {
        logic [7:0] x, y;
        logic       bin;
        logic [7:0] d;
        logic       bout, zero;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Called at a negedge; runs one operation on the W=4 instance and checks it
    task automatic do_op(input vec_t v);
        int n = 0;
        x = v.x; y = v.y; bin = v.bin; start = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
        end while (!done && n < 20);
        check("latency", n, 3);
        check("d", d, v.d);
        check("bout", bout, v.bout);
        check("zero", zero, v.zero);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("ready_idle", ready, 1);
    endtask

    vec_t vt[8];

    initial begin
        int n, ndone;
        logic [7:0] dcap;
        vt[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[1] = '{8'hDB, 8'h93, 1'b1, 8'h47, 1'b0, 1'b0};
        vt[2] = '{8'h05, 8'h31, 1'b0, 8'hD4, 1'b1, 1'b0};
        vt[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[4] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vt[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1};
        vt[6] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0};
        vt[7] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d", d, 0);
        check("rst_bout", bout, 0);
        check("rst_zero", zero, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) do_op(vt[i]);

        // back-to-back: new start on the done cycle is accepted without a bubble
        x = 8'h05; y = 8'h31; bin = 1'b0; start = 1'b1; n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
        end while (!done && n < 20);
        check("b2b_first_done", done, 1);
        check("b2b_first_d", d, 8'hD4);
        check("b2b_first_bout", bout, 1);
        x = 8'h00; y = 8'h00; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x = 8'hAA; y = 8'h11; bin = 1'b0;
        check("b2b_accepted", busy, 1);
        check("b2b_d_held", d, 8'hD4);
        n = 1;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        check("b2b_latency", n, 3);
        check("b2b_d", d, 8'hFF);
        check("b2b_bout", bout, 1);
        check("b2b_zero", zero, 0);
        @(negedge clk);

        // start while busy is ignored, operand changes after acceptance ignored
        x = 8'h10; y = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        check("busy_ready_low", ready, 0);
        x = 8'hFF; y = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; dcap = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                dcap = d;
            end
        end
        check("busy_done_count", ndone, 1);
        check("busy_d", dcap, 8'h0F);
        check("busy_bout", bout, 0);

        // asynchronous reset mid-operation discards it
        x = 8'h12; y = 8'h34; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_d", d, 0);
        check("mid_rst_bout", bout, 0);
        check("mid_rst_zero", zero, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("mid_rst_no_done", ndone, 0);
        do_op('{8'h9C, 8'h3A, 1'b1, 8'h61, 1'b0, 1'b0});

        // random vectors on the W=1 and W=8 instances against a 9-bit reference
        for (int k = 0; k < 200; k++) begin
            logic [8:0] exp;
            int n1, n8;
            rx = 8'($urandom); ry = 8'($urandom); rbin = 1'($urandom);
            exp = {1'b0, rx} - {1'b0, ry} - {8'b0, rbin};
            rstart = 1'b1; n1 = 0; n8 = 0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    rstart = 1'b0;
                    rx = ~rx; ry = ~ry; rbin = ~rbin;
                end
                if (done1 && n1 == 0) begin
                    n1 = c;
                    check("w1_result", {bout1, d1}, exp);
                    check("w1_zero", zero1, exp[7:0] == 0);
                end
                if (done8 && n8 == 0) begin
                    n8 = c;
                    check("w8_result", {bout8, d8}, exp);
                    check("w8_zero", zero8, exp[7:0] == 0);
                end
            end
            check("w1_latency", n1, 9);
            check("w8_latency", n8, 2);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
